// File: rtl/mac_array_acc.sv
// Multi-lane MAC: per-lane unsigned x signed products, lane sum, windowed signed accumulation with saturate/wrap.
// Latency: two registered stages, input edge to out update. No backpressure, so one vector is accepted every cycle.
module mac_array_acc #(
   parameter int BW      = 4,
   parameter int PSUM_BW = 16,
   parameter int COL     = 4,
   parameter int ACC_LEN = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [BW*COL-1:0]         x,
   input  logic [BW*COL-1:0]         w,
   input  logic                      in_valid,
   input  logic                      clear,
   input  logic                      sat_en,
   output logic signed [PSUM_BW-1:0] out,
   output logic                      out_valid,
   output logic                      out_ovf
);

   localparam int PW = 2*BW + 1;
   localparam int SW = PSUM_BW + $clog2(COL) + PW;
   localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

   localparam logic signed [SW-1:0] PMAX = {{(SW-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
   localparam logic signed [SW-1:0] PMIN = {{(SW-PSUM_BW+1){1'b1}}, {(PSUM_BW-1){1'b0}}};
   localparam logic [PSUM_BW-1:0]   SAT_HI = {1'b0, {(PSUM_BW-1){1'b1}}};
   localparam logic [PSUM_BW-1:0]   SAT_LO = {1'b1, {(PSUM_BW-1){1'b0}}};

   logic signed [PW-1:0]      prod_d [COL];
   logic signed [PW-1:0]      prod_q [COL];
   logic                      s1_vld_d, s1_vld_q;
   logic signed [PSUM_BW-1:0] acc_d, acc_q;
   logic [CW-1:0]             cnt_d, cnt_q;
   logic                      sticky_d, sticky_q;
   logic signed [PSUM_BW-1:0] out_d, out_q;
   logic                      out_vld_d, out_vld_q;
   logic                      out_ovf_d, out_ovf_q;

   logic signed [PW-1:0]      x_ext, w_ext;
   logic signed [SW-1:0]      sum, nxt;
   logic                      step_ovf;
   logic [PSUM_BW-1:0]        res;

   // Stage 1: activations zero-extended, weights sign-extended to the full product width.
   always_comb begin
      s1_vld_d = in_valid & ~clear;
      x_ext    = '0;
      w_ext    = '0;
      for (int k = 0; k < COL; k++) begin
         x_ext     = {{(BW+1){1'b0}}, x[BW*k +: BW]};
         w_ext     = {{(BW+1){w[BW*k+BW-1]}}, w[BW*k +: BW]};
         prod_d[k] = x_ext * w_ext;
      end
   end

   always_comb begin
      sum = '0;
      for (int k = 0; k < COL; k++) begin
         sum = sum + {{(SW-PW){prod_q[k][PW-1]}}, prod_q[k]};
      end
      nxt      = {{(SW-PSUM_BW){acc_q[PSUM_BW-1]}}, acc_q} + sum;
      step_ovf = (nxt > PMAX) || (nxt < PMIN);
      if (step_ovf && sat_en) begin
         res = nxt[SW-1] ? SAT_LO : SAT_HI;
      end else begin
         res = nxt[PSUM_BW-1:0];
      end
   end

   // Stage 2: clear takes priority over a pending stage-1 vector and suppresses any pulse.
   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sticky_d  = sticky_q;
      out_d     = out_q;
      out_ovf_d = out_ovf_q;
      out_vld_d = 1'b0;
      if (clear) begin
         acc_d    = '0;
         cnt_d    = '0;
         sticky_d = 1'b0;
      end else if (s1_vld_q) begin
         if (cnt_q == LAST) begin
            out_d     = res;
            out_ovf_d = sticky_q | step_ovf;
            out_vld_d = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            sticky_d  = 1'b0;
         end else begin
            acc_d    = res;
            cnt_d    = cnt_q + CW'(1);
            sticky_d = sticky_q | step_ovf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < COL; k++) prod_q[k] <= '0;
         s1_vld_q  <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         sticky_q  <= 1'b0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
         out_ovf_q <= 1'b0;
      end else begin
         for (int k = 0; k < COL; k++) prod_q[k] <= prod_d[k];
         s1_vld_q  <= s1_vld_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         sticky_q  <= sticky_d;
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         out_ovf_q <= out_ovf_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_vld_q;
   assign out_ovf   = out_ovf_q;

endmodule
